// File: rtl/scan_test_seq_if.sv
//------------------------------------------------------------------------------
// Module   : scan_test_seq_if
// Brief    : Pattern-beat and response-beat handshake bundle for scan_test_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface scan_test_seq_if #(
    parameter int NUM_CHAINS = 7
);
    logic                  pat_valid;
    logic                  pat_ready;
    logic [NUM_CHAINS-1:0] pat_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [NUM_CHAINS-1:0] resp_data;

    // Pattern source / response sink side.
    modport master (
        output pat_valid,
        output pat_data,
        output resp_ready,
        input  pat_ready,
        input  resp_valid,
        input  resp_data
    );

    // Sequencer side.
    modport slave (
        input  pat_valid,
        input  pat_data,
        input  resp_ready,
        output pat_ready,
        output resp_valid,
        output resp_data
    );
endinterface

`default_nettype wire

// File: rtl/scan_test_seq.sv
//------------------------------------------------------------------------------
// Module   : scan_test_seq
// Brief    : Scan load/capture/unload sequencer with overlapped load/unload.
//            Optional MISR response compaction when SCAN_MISR_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_test_seq #(
    parameter int NUM_CHAINS = 7,
    parameter int CHAIN_LEN  = 40,
    parameter int PAT_W      = 16
) (
    input  wire logic                  CK,
    input  wire logic                  RN,
    input  wire logic                  start,
    input  wire logic [PAT_W-1:0]      num_pat,
    scan_test_seq_if.slave             bus,
    output logic      [NUM_CHAINS-1:0] si,
    input  wire logic [NUM_CHAINS-1:0] so,
    output logic                       scan_en,
    output logic                       dut_ce,
    output logic                       busy,
    output logic                       done,
    output logic      [NUM_CHAINS-1:0] signature
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  rem_q, rem_d;
    logic              first_q, first_d;
    logic              scan_en_q;

    logic                  w_beat_fire;
    logic                  w_dut_ce;
    logic                  w_pat_ready;
    logic                  w_resp_valid;
    logic [NUM_CHAINS-1:0] w_si;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        first_d      = first_q;
        w_beat_fire  = 1'b0;
        w_dut_ce     = 1'b0;
        w_pat_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_si         = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_pat != '0) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        rem_d   = num_pat;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                // Past the first pattern every load beat also unloads a response,
                // so the beat must wait for the response sink as well.
                w_pat_ready  = first_q || bus.resp_ready;
                w_resp_valid = !first_q && bus.pat_valid;
                w_beat_fire  = bus.pat_valid && w_pat_ready;
                w_dut_ce     = w_beat_fire;
                w_si         = bus.pat_data;
                if (w_beat_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_CAPTURE: begin
                w_dut_ce = 1'b1;
                rem_d    = rem_q - PAT_W'(1);
                first_d  = 1'b0;
                state_d  = (rem_q != PAT_W'(1)) ? ST_LOAD : ST_UNLOAD;
            end

            ST_UNLOAD: begin
                w_resp_valid = 1'b1;
                w_beat_fire  = bus.resp_ready;
                w_dut_ce     = w_beat_fire;
                if (w_beat_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            scan_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            scan_en_q <= (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
        end
    end

`ifdef SCAN_MISR_EN
    logic [NUM_CHAINS-1:0] misr_q, misr_d;
    logic                  w_start_acc;
    logic                  w_resp_fire;

    assign w_start_acc = (state_q == ST_IDLE) && start;
    assign w_resp_fire = w_resp_valid && bus.resp_ready;

    always_comb begin
        misr_d = misr_q;
        if (w_start_acc) begin
            misr_d = '0;
        end else if (w_resp_fire) begin
            misr_d = {misr_q[NUM_CHAINS-2:0],
                      misr_q[NUM_CHAINS-1] ^ misr_q[NUM_CHAINS-2]} ^ so;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign signature = misr_q;
`else
    assign signature = '0;
`endif

    assign bus.pat_ready  = w_pat_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = w_resp_valid ? so : '0;

    assign si      = w_si;
    assign scan_en = scan_en_q;
    assign dut_ce  = w_dut_ce;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: doc/scan_test_seq.md
SCAN_TEST_SEQ -- requirements
Module: scan_test_seq

Interface
REQ-001 The module SHALL have one parameter NUM_CHAINS, default 7, giving the number of scan chains driven and observed.
REQ-002 The module SHALL have one parameter CHAIN_LEN, default 40, giving the shift beats per load/unload (the longest chain including boundary cells).
REQ-003 The module SHALL have one parameter PAT_W, default 16, giving the width of the pattern-count input.
REQ-004 CK  input  1  clock; all state updates on the rising edge.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to run a test session; honoured only in IDLE.
REQ-007 num_pat  input  PAT_W  pattern count, sampled on an accepted start.
REQ-008 pat_valid / pat_ready  input / output  1 / 1  pattern-beat handshake.
REQ-009 pat_data  input  NUM_CHAINS  one scan-in bit per chain for the current beat.
REQ-010 resp_valid / resp_ready  output / input  1 / 1  response-beat handshake.
REQ-011 resp_data  output  NUM_CHAINS  response bits, equal to so during a response beat.
REQ-012 si / so  output / input  NUM_CHAINS / NUM_CHAINS  scan-in bits to the DUT chains; scan-out bits from the DUT chains.
REQ-013 scan_en  output  1  DUT scan-enable.
REQ-014 dut_ce  output  1  DUT clock enable; integration gates the DUT clock with it.
REQ-015 busy / done  output / output  1 / 1  busy while not IDLE; done is a 1-cycle completion pulse.
REQ-016 signature  output  NUM_CHAINS  MISR result (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, CAPTURE, UNLOAD and DONE.
REQ-018 IDLE: start=1 with num_pat>0 -> LOAD, clearing the beat counter and latching remaining=num_pat; start=1 with num_pat=0 -> DONE.
REQ-019 scan_en SHALL be a registered output, 1 exactly in LOAD and UNLOAD and 0 otherwise.
REQ-020 A beat fires in LOAD with pat_valid && (first pattern || resp_ready) and in UNLOAD with resp_ready.
REQ-021 dut_ce SHALL equal the beat-fire term in LOAD/UNLOAD, 1 in CAPTURE, and 0 in IDLE and DONE; the DUT never advances on a stalled cycle.
REQ-022 si SHALL equal pat_data in LOAD and 0 in every other state.
REQ-023 pat_ready SHALL be LOAD && (first pattern || resp_ready), with no combinational path from pat_valid.
REQ-024 resp_valid SHALL be (LOAD && !first pattern && pat_valid) || UNLOAD.
REQ-025 The beat counter SHALL count fired beats 0..CHAIN_LEN-1; the fire at CHAIN_LEN-1 leaves LOAD for CAPTURE, or leaves UNLOAD for DONE, and wraps the counter to 0.
REQ-026 CAPTURE SHALL last exactly 1 cycle with scan_en=0 and dut_ce=1, then decrement remaining; if remaining becomes >0 -> LOAD (not first pattern), else -> UNLOAD.
REQ-027 Load of pattern n+1 SHALL overlap unload of response n, so a session is num_pat*(CHAIN_LEN+1)+CHAIN_LEN dut_ce cycles.
REQ-028 DONE SHALL last 1 cycle with done=1, then -> IDLE.
REQ-029 start while busy SHALL be ignored.
REQ-030 num_pat SHALL be treated as unsigned, with the full range 1..2^PAT_W-1 supported.

Reset
REQ-031 RN low SHALL force IDLE asynchronously, including mid-session, aborting the session with no done pulse.
REQ-032 On reset the outputs SHALL be: scan_en=0, dut_ce=0, si=0, pat_ready=0, resp_valid=0, busy=0, done=0, signature=0, and the counters SHALL be 0.

Configuration
REQ-033 With SCAN_MISR_EN defined, a NUM_CHAINS-bit MISR SHALL update on every fired response beat as m'[0]=m[N-1]^m[N-2]^so[0] and m'[i]=m[i-1]^so[i], cleared on an accepted start, with signature=m held until the next accepted start.
REQ-034 Without SCAN_MISR_EN, no MISR SHALL be built and signature SHALL be constant 0.

Verification
REQ-035 CHAIN_LEN=4, num_pat=1, pat_data=7'h55 every beat, pat_valid and resp_ready held 1 -> scan_en high 4 cycles, 1 capture cycle, 4 unload beats with resp_valid=1, done on cycle 10 after start.
REQ-036 num_pat=2, pat_valid low for 3 cycles mid-LOAD -> dut_ce=0 and the counter frozen for those cycles, scan_en stays 1, the beat total is unchanged.
REQ-037 resp_ready=0 during the second pattern's LOAD -> pat_ready=0 and dut_ce=0 until resp_ready=1.
REQ-038 start with num_pat=0 -> done on the next cycle, no dut_ce and no scan_en activity.
REQ-039 RN asserted on beat 2 of UNLOAD -> all outputs reach their reset values immediately, no done; a new start then runs a clean session.
REQ-040 With SCAN_MISR_EN, so=7'h01 on every response beat, CHAIN_LEN=4, num_pat=1 -> signature=7'h0F at done; without the macro, signature=0.
